// File: rtl/lycan_pkg.sv
// Lycan shared definitions: pin count, packet
// header layout, peripheral map and FSM encodings.
package lycan_globals;

  localparam int num_dut_pins = 16;

  localparam int addr_msb = 31;
  localparam int addr_lsb = 29;
  localparam int cfg_bit  = 28;
  localparam int cnt_msb  = 27;
  localparam int cnt_lsb  = 26;

  localparam logic [2:0] periph_pins = 3'd0;

  localparam int fifo_depth = 16;
  localparam int fifo_cw    = $clog2(fifo_depth) + 1;

  typedef struct packed {
    logic [2:0]  addr;
    logic        cfg;
    logic [1:0]  cnt;
    logic [1:0]  rsvd;
    logic [23:0] payload;
  } pkt_t;

  typedef enum logic [1:0] {
    rx_idle, rx_turn, rx_read, rx_done
  } rx_state_t;

  typedef enum logic {
    tx_idle, tx_write
  } tx_state_t;

  // Data packet for the pin peripheral with a
  // non-empty payload.
  function automatic logic is_echo(logic [31:0] w);
    return w[addr_msb:addr_lsb] == periph_pins
        && !w[cfg_bit]
        && w[cnt_msb:cnt_lsb] != 2'd0;
  endfunction

endpackage

// File: rtl/lycan_fifo.sv
// Lycan synchronous FIFO with full, almost-full
// (two or fewer free slots) and empty flags.
module lycan_fifo #(
  parameter int width = 32,
  parameter int depth = 16
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           wdata,
  output logic [width-1:0]           rdata,
  output logic                       full,
  output logic                       almost_full,
  output logic                       empty,
  output logic [$clog2(depth):0]     count
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full        = count == cw'(depth);
  assign almost_full = count >= cw'(depth - 2);
  assign empty       = count == '0;
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign rdata       = mem[rd_ptr];

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lycan.sv
// Lycan top: FT601 FIFO bridge, packet dispatch
// to the DUT pin register, echo back to host.
module lycan
  import lycan_globals::*;
(
  input  logic                    clk,
  input  logic                    rst_l,
  inout  wire  [31:0]             usb_data,
  inout  wire  [3:0]              usb_be,
  input  logic                    usb_tx_full,
  input  logic                    usb_rx_empty,
  output logic                    usb_siwu,
  output logic                    usb_wren_l,
  output logic                    usb_rden_l,
  output logic                    usb_outen_l,
  output logic                    usb_rst_l,
  output logic                    usb_wakeup,
  output logic [1:0]              usb_gpio,
  inout  wire  [num_dut_pins-1:0] dut_pins,
  output logic [1:0]              set_vadj,
  output logic                    vadj_en
);

  rx_state_t rx_state;
  tx_state_t tx_state;

  logic [num_dut_pins-1:0] pins_q;

  logic               rx_push, rx_pop;
  pkt_t               rx_head;
  logic               rx_full, rx_af, rx_empty_f;
  logic [fifo_cw-1:0] rx_cnt;

  logic               tx_push, tx_pop;
  logic [31:0]        tx_head;
  logic               tx_full_f, tx_empty_f;
  logic               tx_af_unused;
  logic [fifo_cw-1:0] tx_cnt;

  logic rx_room, rx_start, tx_go, disp;

  assign usb_siwu   = 1'b1;
  assign usb_wakeup = 1'b1;
  assign usb_gpio   = 2'b00;
  assign usb_rst_l  = rst_l;
  assign set_vadj   = 2'b11;
  assign dut_pins   = pins_q;

  assign usb_data = usb_wren_l ? 32'bz : tx_head;
  assign usb_be   = usb_wren_l ? 4'bz : 4'hF;

  assign rx_room  = rx_cnt <= fifo_cw'(fifo_depth - 4);
  assign rx_start = rx_state == rx_idle
                 && tx_state == tx_idle
                 && !usb_rx_empty && rx_room;
  assign tx_go    = tx_state == tx_idle
                 && rx_state == rx_idle
                 && !rx_start && !tx_empty_f
                 && !usb_tx_full;

  assign rx_push = rx_state == rx_read
                && !usb_rx_empty && !rx_full
                && usb_be == 4'hF;
  assign disp    = !rx_empty_f && !tx_full_f;
  assign rx_pop  = disp;
  assign tx_push = disp && is_echo(rx_head);
  assign tx_pop  = tx_state == tx_write
                && !usb_tx_full;

  lycan_fifo #(.width(32), .depth(fifo_depth)) u_rx (
    .clk         (clk),
    .rst_l       (rst_l),
    .push        (rx_push),
    .pop         (rx_pop),
    .wdata       (usb_data),
    .rdata       (rx_head),
    .full        (rx_full),
    .almost_full (rx_af),
    .empty       (rx_empty_f),
    .count       (rx_cnt)
  );

  lycan_fifo #(.width(32), .depth(fifo_depth)) u_tx (
    .clk         (clk),
    .rst_l       (rst_l),
    .push        (tx_push),
    .pop         (tx_pop),
    .wdata       (rx_head),
    .rdata       (tx_head),
    .full        (tx_full_f),
    .almost_full (tx_af_unused),
    .empty       (tx_empty_f),
    .count       (tx_cnt)
  );

  // Read side: turn the bus, burst, turn back.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_state    <= rx_idle;
      usb_outen_l <= 1'b1;
      usb_rden_l  <= 1'b1;
    end else begin
      unique case (rx_state)
        rx_idle: if (rx_start) begin
          rx_state    <= rx_turn;
          usb_outen_l <= 1'b0;
        end
        rx_turn: begin
          rx_state   <= rx_read;
          usb_rden_l <= 1'b0;
        end
        rx_read: if (usb_rx_empty || rx_af) begin
          rx_state    <= rx_done;
          usb_rden_l  <= 1'b1;
          usb_outen_l <= 1'b1;
        end
        rx_done: rx_state <= rx_idle;
      endcase
    end
  end

  // Write side: stream echoes while the bridge has room.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tx_state   <= tx_idle;
      usb_wren_l <= 1'b1;
    end else begin
      unique case (tx_state)
        tx_idle: if (tx_go) begin
          tx_state   <= tx_write;
          usb_wren_l <= 1'b0;
        end
        tx_write: if (usb_tx_full
            || (tx_cnt == fifo_cw'(1) && !tx_push)) begin
          tx_state   <= tx_idle;
          usb_wren_l <= 1'b1;
        end
      endcase
    end
  end

  // Pin register loads from each echoed data packet.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) pins_q <= '0;
    else if (tx_push)
      pins_q <= rx_head.payload[num_dut_pins-1:0];
  end

  // Enable the adjustable supply once out of reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) vadj_en <= 1'b0;
    else        vadj_en <= 1'b1;
  end

endmodule

// File: tb/tb_lycan.sv
// Directed bench for lycan with a small FT601
// bridge model on the host side.
module tb_lycan;

  logic clk = 1'b0;
  logic rst_l = 1'b1;
  logic usb_tx_full = 1'b0;
  logic usb_rx_empty;
  wire  [31:0] usb_data;
  wire  [3:0]  usb_be;
  wire  [15:0] dut_pins;
  logic usb_siwu, usb_wren_l, usb_rden_l;
  logic usb_outen_l, usb_rst_l, usb_wakeup;
  logic [1:0] usb_gpio, set_vadj;
  logic vadj_en;

  always #5 clk = ~clk;

  lycan dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .usb_data     (usb_data),
    .usb_be       (usb_be),
    .usb_tx_full  (usb_tx_full),
    .usb_rx_empty (usb_rx_empty),
    .usb_siwu     (usb_siwu),
    .usb_wren_l   (usb_wren_l),
    .usb_rden_l   (usb_rden_l),
    .usb_outen_l  (usb_outen_l),
    .usb_rst_l    (usb_rst_l),
    .usb_wakeup   (usb_wakeup),
    .usb_gpio     (usb_gpio),
    .dut_pins     (dut_pins),
    .set_vadj     (set_vadj),
    .vadj_en      (vadj_en)
  );

  logic [31:0] qd [64];
  logic [3:0]  qb [64];
  logic [31:0] wlog [64];
  logic [3:0]  blog [64];
  int rd_idx = 0;
  int avail = 0;
  int wn = 0;
  int ecount = 0;
  int cap_edge = 0;
  int chg_edge = 0;
  int bad = 0;
  int wr_low = 0;
  int checks = 0;
  int failures = 0;
  logic po = 1'b1;
  logic pr = 1'b1;
  logic [15:0] prev_dut = '0;

  assign usb_rx_empty = rd_idx >= avail;
  assign usb_data = usb_outen_l ? 32'bz : qd[rd_idx[5:0]];
  assign usb_be   = usb_outen_l ? 4'bz : qb[rd_idx[5:0]];

  // Bridge model: pops on reads, logs accepted writes.
  always @(posedge clk) begin
    ecount <= ecount + 1;
    if (!usb_rden_l && !usb_rx_empty) begin
      rd_idx   <= rd_idx + 1;
      cap_edge <= ecount + 1;
    end
    if (!usb_wren_l && !usb_tx_full) begin
      wlog[wn[5:0]] <= usb_data;
      blog[wn[5:0]] <= usb_be;
      wn <= wn + 1;
    end
  end

  // Strobe ordering and bus turnaround monitor.
  always @(negedge clk) begin
    if (usb_outen_l && !usb_rden_l) bad++;
    if (!usb_outen_l && usb_rden_l && !(po && pr)) bad++;
    if (!usb_outen_l && !usb_rden_l && po) bad++;
    if (!usb_wren_l && (!usb_outen_l || !po)) bad++;
    if (!usb_wren_l) wr_low++;
    if (dut_pins != prev_dut) chg_edge = ecount;
    prev_dut = dut_pins;
    po = usb_outen_l;
    pr = usb_rden_l;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    int w0, l0;
    for (int i = 0; i < 64; i++) begin
      qd[i] = '0;
      qb[i] = 4'hF;
    end
    for (int i = 0; i < 8; i++)
      qd[i] = 32'h0CA5_0000 + i * 32'h111;
    avail = 8;

    #1 rst_l = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_rden", 32'(usb_rden_l), 1);
    check("rst_outen", 32'(usb_outen_l), 1);
    check("rst_wren", 32'(usb_wren_l), 1);
    check("rst_pins", {16'h0, dut_pins}, 0);
    check("rst_vadj_en", 32'(vadj_en), 0);
    check("rst_usb_rst", 32'(usb_rst_l), 0);
    check("set_vadj", 32'(set_vadj), 3);
    check("siwu", 32'(usb_siwu), 1);
    check("wakeup", 32'(usb_wakeup), 1);
    check("gpio", 32'(usb_gpio), 0);
    check("rst_captures", rd_idx, 0);

    rst_l = 1'b1;
    @(negedge clk);
    check("vadj_en", 32'(vadj_en), 1);
    for (int i = 0; i < 300 && wn < 8; i++)
      @(negedge clk);
    check("burst_captures", rd_idx, 8);
    check("burst_writes", wn, 8);
    for (int i = 0; i < 8; i++) begin
      check("burst_word", wlog[i], qd[i]);
      check("burst_be", 32'(blog[i]), 32'hF);
    end
    check("burst_pins", {16'h0, dut_pins}, 32'h0777);
    check("pin_latency", chg_edge - cap_edge, 1);
    check("burst_rden", 32'(usb_rden_l), 1);
    check("burst_outen", 32'(usb_outen_l), 1);

    for (int i = 8; i < 14; i++)
      qd[i] = 32'h0CB0_0000 + (i - 7);
    avail = 11;
    for (int i = 0; i < 100 && !(rd_idx >= 11 && usb_rden_l); i++)
      @(negedge clk);
    repeat (5) @(negedge clk);
    check("pause_captures", rd_idx, 11);
    avail = 14;
    for (int i = 0; i < 300 && wn < 14; i++)
      @(negedge clk);
    check("resume_captures", rd_idx, 14);
    check("resume_writes", wn, 14);
    for (int i = 8; i < 14; i++)
      check("resume_word", wlog[i], qd[i]);
    check("resume_pins", {16'h0, dut_pins}, 32'h0006);

    usb_tx_full = 1'b1;
    w0 = wn;
    l0 = wr_low;
    qd[14] = 32'h0CC0_1234;
    qd[15] = 32'h0CC0_5678;
    avail = 16;
    repeat (30) @(negedge clk);
    check("full_wren_low", wr_low - l0, 0);
    check("full_writes", wn, w0);
    check("full_captures", rd_idx, 16);
    check("full_pins", {16'h0, dut_pins}, 32'h5678);
    usb_tx_full = 1'b0;
    for (int i = 0; i < 100 && wn < 16; i++)
      @(negedge clk);
    check("drain_writes", wn, 16);
    check("drain_word0", wlog[14], 32'h0CC0_1234);
    check("drain_word1", wlog[15], 32'h0CC0_5678);

    qd[16] = 32'h6C00_9999;
    qd[17] = 32'h1C00_8888;
    qd[18] = 32'h0CC0_7777;
    qb[18] = 4'h7;
    qd[19] = 32'h0000_6666;
    avail = 20;
    repeat (40) @(negedge clk);
    check("drop_captures", rd_idx, 20);
    check("drop_writes", wn, 16);
    check("drop_pins", {16'h0, dut_pins}, 32'h5678);

    for (int i = 20; i < 28; i++)
      qd[i] = 32'h0CD0_0000 + i;
    avail = 28;
    for (int i = 0; i < 50 && usb_rden_l; i++)
      @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst_l = 1'b0;
    avail = rd_idx;
    #1;
    check("mid_rst_rden", 32'(usb_rden_l), 1);
    check("mid_rst_outen", 32'(usb_outen_l), 1);
    check("mid_rst_wren", 32'(usb_wren_l), 1);
    check("mid_rst_pins", {16'h0, dut_pins}, 0);
    check("mid_rst_captured", 32'(rd_idx > 20), 1);
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_writes", wn, 16);
    check("post_rst_pins", {16'h0, dut_pins}, 0);
    check("post_rst_rden", 32'(usb_rden_l), 1);
    check("strobe_order", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
